clk_lock_ctrl: RTL and testbench

Lock sequencer for the 78 MHz MMCM clocking wrapper in the ADC datapath. It drives the MMCM reset, monitors the asynchronous `locked` flag, and holds the 78 MHz domain in reset until lock has been stable for a programmable interval. It retries on lock timeout and latches a fault after repeated failures. It counts lock-loss events while running. It runs entirely on the 100 MHz board clock, so it remains alive while the MMCM output is absent.

---
 rtl/clk_lock_ctrl.sv | 136 +++++++++++++
 tb/tb_clk_lock_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_lock_ctrl.sv
// MMCM lock sequencer: pulses the MMCM reset, waits for a stable synchronized lock,
// retries on timeout, latches a fault after repeated failures and counts lock losses in RUN.
module clk_lock_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRIES      = 4
) (
    input  logic       clk_100MHz_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       relock_req_i,
    output logic       mmcm_rst_o,
    output logic       dom_rst_o,
    output logic       clk_ready_o,
    output logic       fault_o,
    output logic [2:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int TMR_MAX_A = (LOCK_TIMEOUT_CYC > STABLE_CYC) ? LOCK_TIMEOUT_CYC : STABLE_CYC;
    localparam int TMR_MAX   = (TMR_MAX_A > RST_PULSE_CYC) ? TMR_MAX_A : RST_PULSE_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYC - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_MMCM,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [2:0]       retry_reg, retry_next;
    logic [7:0]       loss_reg, loss_next;
    logic             locked_meta_reg, locked_s_reg;
    logic             mmcm_rst_reg, clk_ready_reg, fault_reg;

    // Outcome of a failed attempt (timeout or lock dropped while stabilizing)
    logic             retries_exhausted;
    state_t           fail_state;
    logic [2:0]       fail_retry;

    assign retries_exhausted = (retry_reg == RETRY_MAX);
    assign fail_state        = retries_exhausted ? ST_FAULT : ST_RESET_MMCM;
    assign fail_retry        = retries_exhausted ? retry_reg : retry_reg + 3'd1;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        case (state_reg)
            ST_RESET_MMCM: begin
                if (timer_reg == RST_LAST) state_next = ST_WAIT_LOCK;
                else                       timer_next = timer_reg + TMR_W'(1);
            end
            ST_WAIT_LOCK: begin
                if (locked_s_reg) begin
                    state_next = ST_STABILIZE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = fail_state;
                    retry_next = fail_retry;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_STABILIZE: begin
                if (!locked_s_reg) begin
                    state_next = fail_state;
                    retry_next = fail_retry;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 3'd0;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_RUN: begin
                // A loss takes priority over a relock so it is always counted
                if (!locked_s_reg) begin
                    if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
                    state_next = ST_RESET_MMCM;
                end else if (relock_req_i) begin
                    state_next = ST_RESET_MMCM;
                end
            end
            ST_FAULT: begin
                if (relock_req_i) begin
                    state_next = ST_RESET_MMCM;
                    retry_next = 3'd0;
                end
            end
            default: state_next = ST_RESET_MMCM;
        endcase
        if (state_next != state_reg) timer_next = '0;
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (rst_i) begin
            state_reg       <= ST_RESET_MMCM;
            timer_reg       <= '0;
            retry_reg       <= 3'd0;
            loss_reg        <= 8'd0;
            locked_meta_reg <= 1'b0;
            locked_s_reg    <= 1'b0;
            mmcm_rst_reg    <= 1'b1;
            clk_ready_reg   <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            retry_reg       <= retry_next;
            loss_reg        <= loss_next;
            locked_meta_reg <= locked_i;
            locked_s_reg    <= locked_meta_reg;
            mmcm_rst_reg    <= (state_next == ST_RESET_MMCM) || (state_next == ST_FAULT);
            clk_ready_reg   <= (state_next == ST_RUN);
            fault_reg       <= (state_next == ST_FAULT);
        end
    end

    assign mmcm_rst_o      = mmcm_rst_reg;
    assign clk_ready_o     = clk_ready_reg;
    assign dom_rst_o       = ~clk_ready_reg;
    assign fault_o         = fault_reg;
    assign retry_cnt_o     = retry_reg;
    assign lock_loss_cnt_o = loss_reg;

endmodule

// File: tb/tb_clk_lock_ctrl.sv
// Bench for clk_lock_ctrl: directed bring-up scenarios plus random lock/relock traffic,
// every cycle compared against a phase/deadline model of the sequencer.
module tb_clk_lock_ctrl;

    localparam int P_RST = 4;
    localparam int P_TO  = 50;
    localparam int P_STB = 8;
    localparam int P_MAX = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       relock = 1'b0;
    logic       mmcm_rst, dom_rst, clk_ready, fault;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // model: current phase, edge number at which it was entered, counters, lock history
    int m_mode, m_t0, m_edge, m_retry, m_loss;
    bit m_h0, m_h1;

    clk_lock_ctrl #(
        .RST_PULSE_CYC(P_RST),
        .LOCK_TIMEOUT_CYC(P_TO),
        .STABLE_CYC(P_STB),
        .MAX_RETRIES(P_MAX)
    ) dut (
        .clk_100MHz_i(clk),
        .rst_i(rst),
        .locked_i(locked),
        .relock_req_i(relock),
        .mmcm_rst_o(mmcm_rst),
        .dom_rst_o(dom_rst),
        .clk_ready_o(clk_ready),
        .fault_o(fault),
        .retry_cnt_o(retry_cnt),
        .lock_loss_cnt_o(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic m_enter(input int ph);
        m_mode = ph;
        m_t0   = m_edge;
    endtask

    task automatic m_fail();
        if (m_retry == P_MAX) m_enter(PH_FAULT);
        else begin
            m_retry++;
            m_enter(PH_PULSE);
        end
    endtask

    task automatic m_step(input bit r, input bit lk, input bit rq);
        bit ls;
        int age;
        m_edge++;
        if (r) begin
            m_enter(PH_PULSE);
            m_retry = 0;
            m_loss  = 0;
            m_h0    = 0;
            m_h1    = 0;
            return;
        end
        ls  = m_h1;
        age = m_edge - m_t0;
        case (m_mode)
            PH_PULSE: if (age >= P_RST) m_enter(PH_WAIT);
            PH_WAIT:  if (ls) m_enter(PH_STAB); else if (age >= P_TO) m_fail();
            PH_STAB: begin
                if (!ls) m_fail();
                else if (age >= P_STB) begin
                    m_retry = 0;
                    m_enter(PH_RUN);
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    m_enter(PH_PULSE);
                end else if (rq) m_enter(PH_PULSE);
            end
            default: if (rq) begin
                m_retry = 0;
                m_enter(PH_PULSE);
            end
        endcase
        m_h1 = m_h0;
        m_h0 = lk;
    endtask

    task automatic tick();
        int exp_ready;
        @(posedge clk);
        m_step(rst, locked, relock);
        #1;
        exp_ready = (m_mode == PH_RUN) ? 1 : 0;
        chk("mmcm_rst", int'(mmcm_rst), (m_mode == PH_PULSE || m_mode == PH_FAULT) ? 1 : 0);
        chk("clk_ready", int'(clk_ready), exp_ready);
        chk("dom_rst", int'(dom_rst), 1 - exp_ready);
        chk("fault", int'(fault), (m_mode == PH_FAULT) ? 1 : 0);
        chk("retry_cnt", int'(retry_cnt), m_retry);
        chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        relock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!clk_ready && n < budget) begin
            tick();
            n++;
        end
        if (!clk_ready) chk("ready_timeout", 0, 1);
    endtask

    initial begin
        int pulse_len, ready_at, rises, prev, fault_at, loss0, fall_at;
        int rise_t[$];

        // reset values
        locked = 1'b0;
        do_reset();
        chk("rst_mmcm", int'(mmcm_rst), 1);
        chk("rst_dom", int'(dom_rst), 1);
        chk("rst_ready", int'(clk_ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_loss", int'(lock_loss_cnt), 0);

        // normal bring-up, locked rises 10 cycles after reset release
        pulse_len = int'(mmcm_rst);
        ready_at  = -1;
        for (int i = 0; i < 40; i++) begin
            locked = (i >= 10);
            tick();
            if (mmcm_rst && pulse_len == i + 1) pulse_len++;
            if (clk_ready && ready_at < 0) ready_at = i;
        end
        chk("bringup_pulse_len", pulse_len, P_RST);
        chk("bringup_ready_lat", ready_at - 9, 3 + P_STB);
        chk("bringup_retry", int'(retry_cnt), 0);

        // one-cycle lock glitch after 5 cycles in STABILIZE
        do_reset();
        locked = 1'b1;
        rises = 0;
        prev = int'(mmcm_rst);
        ready_at = 0;
        for (int i = 0; i < 12; i++) begin
            locked = (i != 8);
            tick();
            if (mmcm_rst && prev == 0) rises++;
            prev = int'(mmcm_rst);
            if (clk_ready) ready_at = 1;
        end
        chk("glitch_rises", rises, 1);
        chk("glitch_ready", ready_at, 0);
        chk("glitch_retry", int'(retry_cnt), 1);
        wait_ready(100);

        // lock never arrives: retries then fault
        locked = 1'b0;
        do_reset();
        prev = int'(mmcm_rst);
        fault_at = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (mmcm_rst && prev == 0 && !fault) rise_t.push_back(i);
            prev = int'(mmcm_rst);
            if (fault && fault_at < 0) fault_at = i;
        end
        chk("timeout_pulses", rise_t.size(), P_MAX);
        if (rise_t.size() >= 2) chk("timeout_spacing", rise_t[1] - rise_t[0], P_RST + P_TO);
        chk("timeout_fault_at", fault_at, -1 + (P_MAX + 1) * (P_RST + P_TO));
        chk("fault_mmcm", int'(mmcm_rst), 1);
        chk("fault_retry", int'(retry_cnt), P_MAX);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_fault", int'(fault), 0);
        chk("relock_retry", int'(retry_cnt), 0);
        chk("relock_mmcm", int'(mmcm_rst), 1);
        locked = 1'b1;
        wait_ready(100);

        // simultaneous lock loss and relock request in RUN
        loss0 = int'(lock_loss_cnt);
        rises = 0;
        prev = int'(mmcm_rst);
        fall_at = -1;
        for (int i = 0; i < 30; i++) begin
            locked = (i >= 3);
            relock = (i == 2);
            tick();
            if (mmcm_rst && prev == 0) rises++;
            prev = int'(mmcm_rst);
            if (!clk_ready && fall_at < 0) fall_at = i;
        end
        relock = 1'b0;
        chk("simul_rises", rises, 1);
        chk("simul_loss", int'(lock_loss_cnt), loss0 + 1);
        chk("loss_ready_lat", fall_at + 1, 3);
        wait_ready(100);

        // repeated lock loss saturates the counter
        for (int k = 0; k < 300; k++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            tick();
            tick();
            wait_ready(100);
        end
        chk("loss_saturated", int'(lock_loss_cnt), 255);

        // reset in the middle of STABILIZE
        do_reset();
        locked = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("midrst_mmcm", int'(mmcm_rst), 1);
        chk("midrst_dom", int'(dom_rst), 1);
        chk("midrst_ready", int'(clk_ready), 0);
        chk("midrst_retry", int'(retry_cnt), 0);
        chk("midrst_loss", int'(lock_loss_cnt), 0);
        rst = 1'b0;
        pulse_len = int'(mmcm_rst);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mmcm_rst && pulse_len == i + 1) pulse_len++;
        end
        chk("midrst_pulse_len", pulse_len, P_RST);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) locked = ~locked;
            relock = ($urandom_range(0, 29) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
